// File: rtl/alu_pkg.sv
// Shared constants for the MIPS-style ALU issue path: opcode/funct encodings,
// one-hot alu_control bit positions and operand-select codes.
package alu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam int unsigned CTL_ADD  = 11;
    localparam int unsigned CTL_SUB  = 10;
    localparam int unsigned CTL_SLT  = 9;
    localparam int unsigned CTL_SLTU = 8;
    localparam int unsigned CTL_AND  = 7;
    localparam int unsigned CTL_NOR  = 6;
    localparam int unsigned CTL_OR   = 5;
    localparam int unsigned CTL_XOR  = 4;
    localparam int unsigned CTL_SLL  = 3;
    localparam int unsigned CTL_SRL  = 2;
    localparam int unsigned CTL_SRA  = 1;
    localparam int unsigned CTL_LUI  = 0;

    localparam logic [11:0] CTL_NOP = 12'h000;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RS_RT,
        SEL_SHAMT_RT,
        SEL_RS_SIMM,
        SEL_RS_ZIMM,
        SEL_ZERO_ZIMM
    } opnd_sel_e;

    function automatic logic [11:0] ctl_bit(input int unsigned pos);
        ctl_bit = 12'b1 << pos;
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Request, ALU and result-stream signals between the issue front end and
// its environment (instruction source, alu, register writeback).
interface alu_issue_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_instr;
    logic [DATA_WIDTH-1:0] in_rs_val;
    logic [DATA_WIDTH-1:0] in_rt_val;

    logic [11:0]           alu_control;
    logic [DATA_WIDTH-1:0] alu_src1;
    logic [DATA_WIDTH-1:0] alu_src2;
    logic [DATA_WIDTH-1:0] alu_result;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_result;
    logic [4:0]            out_rd;
    logic                  out_err;

    modport master (
        output in_valid, in_instr, in_rs_val, in_rt_val, alu_result, out_ready,
        input  in_ready, alu_control, alu_src1, alu_src2,
               out_valid, out_result, out_rd, out_err
    );

    modport slave (
        input  in_valid, in_instr, in_rs_val, in_rt_val, alu_result, out_ready,
        output in_ready, alu_control, alu_src1, alu_src2,
               out_valid, out_result, out_rd, out_err
    );
endinterface

// File: rtl/alu_issue_decode.sv
// Combinational decode of one MIPS ALU instruction into a one-hot alu_control
// word, the two ALU operands, the destination register and an unsupported flag.
module alu_issue_decode
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [31:0]           instr,
    input  logic [DATA_WIDTH-1:0] rs_val,
    input  logic [DATA_WIDTH-1:0] rt_val,
    output logic [11:0]           control,
    output logic [DATA_WIDTH-1:0] src1,
    output logic [DATA_WIDTH-1:0] src2,
    output logic [4:0]            rd,
    output logic                  err
);
    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic [DATA_WIDTH-1:0] simm;
    logic [DATA_WIDTH-1:0] zimm;
    logic [DATA_WIDTH-1:0] shamt;
    opnd_sel_e             sel;
    logic                  rs_field_unused;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign simm   = {{(DATA_WIDTH-16){instr[15]}}, instr[15:0]};
    assign zimm   = {{(DATA_WIDTH-16){1'b0}}, instr[15:0]};
    assign shamt  = {{(DATA_WIDTH-5){1'b0}}, instr[10:6]};

    // Register numbers in rs/rt are resolved upstream; only their values arrive here.
    assign rs_field_unused = ^instr[25:21];

    always_comb begin
        control = CTL_NOP;
        sel     = SEL_NONE;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_ADD, FN_ADDU: begin control = ctl_bit(CTL_ADD);  sel = SEL_RS_RT;    end
                FN_SUB, FN_SUBU: begin control = ctl_bit(CTL_SUB);  sel = SEL_RS_RT;    end
                FN_SLT:          begin control = ctl_bit(CTL_SLT);  sel = SEL_RS_RT;    end
                FN_SLTU:         begin control = ctl_bit(CTL_SLTU); sel = SEL_RS_RT;    end
                FN_AND:          begin control = ctl_bit(CTL_AND);  sel = SEL_RS_RT;    end
                FN_OR:           begin control = ctl_bit(CTL_OR);   sel = SEL_RS_RT;    end
                FN_XOR:          begin control = ctl_bit(CTL_XOR);  sel = SEL_RS_RT;    end
                FN_NOR:          begin control = ctl_bit(CTL_NOR);  sel = SEL_RS_RT;    end
                FN_SLL:          begin control = ctl_bit(CTL_SLL);  sel = SEL_SHAMT_RT; end
                FN_SRL:          begin control = ctl_bit(CTL_SRL);  sel = SEL_SHAMT_RT; end
                FN_SRA:          begin control = ctl_bit(CTL_SRA);  sel = SEL_SHAMT_RT; end
                FN_SLLV:         begin control = ctl_bit(CTL_SLL);  sel = SEL_RS_RT;    end
                FN_SRLV:         begin control = ctl_bit(CTL_SRL);  sel = SEL_RS_RT;    end
                FN_SRAV:         begin control = ctl_bit(CTL_SRA);  sel = SEL_RS_RT;    end
                default: ;
            endcase
        end else begin
            case (opcode)
                OP_ADDI, OP_ADDIU: begin control = ctl_bit(CTL_ADD);  sel = SEL_RS_SIMM;   end
                OP_SLTI:           begin control = ctl_bit(CTL_SLT);  sel = SEL_RS_SIMM;   end
                OP_SLTIU:          begin control = ctl_bit(CTL_SLTU); sel = SEL_RS_SIMM;   end
                OP_ANDI:           begin control = ctl_bit(CTL_AND);  sel = SEL_RS_ZIMM;   end
                OP_ORI:            begin control = ctl_bit(CTL_OR);   sel = SEL_RS_ZIMM;   end
                OP_XORI:           begin control = ctl_bit(CTL_XOR);  sel = SEL_RS_ZIMM;   end
                OP_LUI:            begin control = ctl_bit(CTL_LUI);  sel = SEL_ZERO_ZIMM; end
                default: ;
            endcase
        end
    end

    always_comb begin
        src1 = '0;
        src2 = '0;
        case (sel)
            SEL_RS_RT:     begin src1 = rs_val; src2 = rt_val; end
            SEL_SHAMT_RT:  begin src1 = shamt;  src2 = rt_val; end
            SEL_RS_SIMM:   begin src1 = rs_val; src2 = simm;   end
            SEL_RS_ZIMM:   begin src1 = rs_val; src2 = zimm;   end
            SEL_ZERO_ZIMM: begin src2 = zimm;                  end
            default: ;
        endcase
    end

    // Every supported encoding sets exactly one control bit.
    assign err = (control == CTL_NOP);
    assign rd  = (opcode == OP_RTYPE) ? instr[15:11] : instr[20:16];

endmodule

// File: rtl/alu_issue.sv
// Two-stage elastic issue/writeback pipe in front of the combinational alu:
// stage 1 drives the ALU operands, stage 2 captures the result for writeback.
module alu_issue
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    alu_issue_if.slave bus
);
    logic [11:0]           dec_ctl;
    logic [DATA_WIDTH-1:0] dec_src1;
    logic [DATA_WIDTH-1:0] dec_src2;
    logic [4:0]            dec_rd;
    logic                  dec_err;

    logic                  s1_valid;
    logic [11:0]           s1_ctl;
    logic [DATA_WIDTH-1:0] s1_src1;
    logic [DATA_WIDTH-1:0] s1_src2;
    logic [4:0]            s1_rd;
    logic                  s1_err;

    logic                  s2_valid;
    logic [DATA_WIDTH-1:0] s2_result;
    logic [4:0]            s2_rd;
    logic                  s2_err;

    logic                  s2_free;
    logic                  s1_adv;
    logic                  accept;

    alu_issue_decode #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_decode (
        .instr   (bus.in_instr),
        .rs_val  (bus.in_rs_val),
        .rt_val  (bus.in_rt_val),
        .control (dec_ctl),
        .src1    (dec_src1),
        .src2    (dec_src2),
        .rd      (dec_rd),
        .err     (dec_err)
    );

    assign s2_free = !s2_valid || bus.out_ready;
    assign s1_adv  = s1_valid && s2_free;
    assign accept  = bus.in_valid && bus.in_ready;

    assign bus.in_ready = !s1_valid || s2_free;

    // Stage 1 is zeroed when it drains so the ALU sees a no-op while empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_ctl   <= CTL_NOP;
            s1_src1  <= '0;
            s1_src2  <= '0;
            s1_rd    <= '0;
            s1_err   <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_ctl   <= dec_ctl;
            s1_src1  <= dec_src1;
            s1_src2  <= dec_src2;
            s1_rd    <= dec_rd;
            s1_err   <= dec_err;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
            s1_ctl   <= CTL_NOP;
            s1_src1  <= '0;
            s1_src2  <= '0;
            s1_rd    <= '0;
            s1_err   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_rd     <= '0;
            s2_err    <= 1'b0;
        end else if (s1_adv) begin
            s2_valid  <= 1'b1;
            s2_result <= s1_err ? '0 : bus.alu_result;
            s2_rd     <= s1_rd;
            s2_err    <= s1_err;
        end else if (bus.out_ready) begin
            s2_valid  <= 1'b0;
        end
    end

    assign bus.alu_control = s1_ctl;
    assign bus.alu_src1    = s1_src1;
    assign bus.alu_src2    = s1_src2;

    assign bus.out_valid   = s2_valid;
    assign bus.out_result  = s2_result;
    assign bus.out_rd      = s2_rd;
    assign bus.out_err     = s2_err;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: behavioural alu plus an instruction-semantics reference
// model and an in-order scoreboard for directed and randomized streams.
module tb_alu_issue;

    localparam int DW = 32;

    typedef struct {
        logic [11:0] ctl;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_issue_if #(.DATA_WIDTH(DW)) bus ();

    alu_issue #(.DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    exp_t q[$];
    logic [5:0] fn_tab [0:16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                                  6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h01};

    // Behavioural alu; a no-op control returns junk so the forced zero is visible.
    function automatic logic [31:0] alu_model(logic [11:0] c, logic [31:0] a, logic [31:0] b);
        case (c)
            12'h800: return a + b;
            12'h400: return a - b;
            12'h200: return {31'b0, $signed(a) < $signed(b)};
            12'h100: return {31'b0, a < b};
            12'h080: return a & b;
            12'h040: return ~(a | b);
            12'h020: return a | b;
            12'h010: return a ^ b;
            12'h008: return b << a[4:0];
            12'h004: return b >> a[4:0];
            12'h002: return $signed(b) >>> a[4:0];
            12'h001: return b << 16;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always_comb bus.alu_result = alu_model(bus.alu_control, bus.alu_src1, bus.alu_src2);

    function automatic exp_t mk(logic [11:0] c, logic [31:0] a, logic [31:0] b,
                                logic [31:0] r, logic [4:0] d);
        exp_t e;
        e.ctl = c; e.s1 = a; e.s2 = b; e.res = r; e.rd = d; e.err = 1'b0;
        return e;
    endfunction

    function automatic exp_t ref_model(logic [31:0] ins, logic [31:0] rs, logic [31:0] rt);
        logic [5:0]  op   = ins[31:26];
        logic [5:0]  fn   = ins[5:0];
        logic [4:0]  sh   = ins[10:6];
        logic [4:0]  rdr  = ins[15:11];
        logic [4:0]  rdi  = ins[20:16];
        logic [31:0] simm = {{16{ins[15]}}, ins[15:0]};
        logic [31:0] zimm = {16'b0, ins[15:0]};
        exp_t e = mk(12'h000, 32'h0, 32'h0, 32'h0, 5'd0);
        e.err = 1'b1;
        if (op == 6'h00) begin
            case (fn)
                6'h20, 6'h21: e = mk(12'h800, rs, rt, rs + rt, rdr);
                6'h22, 6'h23: e = mk(12'h400, rs, rt, rs - rt, rdr);
                6'h2A: e = mk(12'h200, rs, rt, {31'b0, $signed(rs) < $signed(rt)}, rdr);
                6'h2B: e = mk(12'h100, rs, rt, {31'b0, rs < rt}, rdr);
                6'h24: e = mk(12'h080, rs, rt, rs & rt, rdr);
                6'h25: e = mk(12'h020, rs, rt, rs | rt, rdr);
                6'h26: e = mk(12'h010, rs, rt, rs ^ rt, rdr);
                6'h27: e = mk(12'h040, rs, rt, ~(rs | rt), rdr);
                6'h00: e = mk(12'h008, {27'b0, sh}, rt, rt << sh, rdr);
                6'h02: e = mk(12'h004, {27'b0, sh}, rt, rt >> sh, rdr);
                6'h03: e = mk(12'h002, {27'b0, sh}, rt, $signed(rt) >>> sh, rdr);
                6'h04: e = mk(12'h008, rs, rt, rt << rs[4:0], rdr);
                6'h06: e = mk(12'h004, rs, rt, rt >> rs[4:0], rdr);
                6'h07: e = mk(12'h002, rs, rt, $signed(rt) >>> rs[4:0], rdr);
                default: ;
            endcase
        end else begin
            case (op)
                6'h08, 6'h09: e = mk(12'h800, rs, simm, rs + simm, rdi);
                6'h0A: e = mk(12'h200, rs, simm, {31'b0, $signed(rs) < $signed(simm)}, rdi);
                6'h0B: e = mk(12'h100, rs, simm, {31'b0, rs < simm}, rdi);
                6'h0C: e = mk(12'h080, rs, zimm, rs & zimm, rdi);
                6'h0D: e = mk(12'h020, rs, zimm, rs | zimm, rdi);
                6'h0E: e = mk(12'h010, rs, zimm, rs ^ zimm, rdi);
                6'h0F: e = mk(12'h001, 32'h0, zimm, {ins[15:0], 16'h0}, rdi);
                default: ;
            endcase
        end
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w = $urandom();
        int unsigned k = $urandom_range(0, 9);
        if (k < 5) begin
            w[31:26] = 6'h00;
            w[5:0]   = fn_tab[$urandom_range(0, 16)];
        end else if (k < 9) begin
            w[31:26] = 6'($urandom_range(8, 15));
        end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_one(input string tag, input logic [31:0] ins,
                             input logic [31:0] rs, input logic [31:0] rt);
        exp_t e = ref_model(ins, rs, rt);
        bus.in_instr  = ins;
        bus.in_rs_val = rs;
        bus.in_rt_val = rt;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk({tag, ".ctl"},  32'(bus.alu_control), 32'(e.ctl));
        chk({tag, ".src1"}, bus.alu_src1, e.s1);
        chk({tag, ".src2"}, bus.alu_src2, e.s2);
        chk({tag, ".early_valid"}, 32'(bus.out_valid), 32'd0);
        tick();
        chk({tag, ".out_valid"},  32'(bus.out_valid), 32'd1);
        chk({tag, ".out_result"}, bus.out_result, e.res);
        chk({tag, ".out_err"},    32'(bus.out_err), 32'(e.err));
        if (!e.err) chk({tag, ".out_rd"}, 32'(bus.out_rd), 32'(e.rd));
        tick();
        chk({tag, ".drained"}, 32'(bus.out_valid), 32'd0);
    endtask

    // mode 0: back-to-back with out_ready 1,0,0 repeating; 1: random; 2: full
    // throughput from an empty pipe; 3: drain only.
    task automatic run_stream(input string tag, input int ncyc, input int mode);
        logic        prev_stall = 1'b0;
        logic        prev_full  = 1'b0;
        logic [31:0] h_res = '0, h_s1 = '0, h_s2 = '0;
        logic [11:0] h_ctl = '0;
        logic [4:0]  h_rd = '0;
        logic        h_err = 1'b0;
        exp_t        e;
        for (int k = 0; k < ncyc; k++) begin
            case (mode)
                0:       begin bus.out_ready = (k % 3 == 0); bus.in_valid = 1'b1; end
                1:       begin bus.out_ready = ($urandom_range(0, 2) != 0);
                               bus.in_valid  = ($urandom_range(0, 3) != 0); end
                2:       begin bus.out_ready = 1'b1; bus.in_valid = 1'b1; end
                default: begin bus.out_ready = 1'b1; bus.in_valid = 1'b0; end
            endcase
            bus.in_instr  = gen_instr();
            bus.in_rs_val = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
            bus.in_rt_val = $urandom();
            #1;
            chk({tag, ".in_ready"}, 32'(bus.in_ready),
                32'(!(q.size() == 2 && !bus.out_ready)));
            if (mode == 2) chk({tag, ".tput_valid"}, 32'(bus.out_valid), 32'(k >= 2));
            if (prev_stall) begin
                chk({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
                chk({tag, ".hold_result"}, bus.out_result, h_res);
                chk({tag, ".hold_rd_err"}, {26'b0, h_err, h_rd}, {26'b0, bus.out_err, bus.out_rd});
                if (prev_full) begin
                    chk({tag, ".hold_ctl"}, 32'(bus.alu_control), 32'(h_ctl));
                    chk({tag, ".hold_src"}, bus.alu_src1 ^ bus.alu_src2, h_s1 ^ h_s2);
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_full  = (q.size() == 2);
            h_res = bus.out_result; h_rd = bus.out_rd; h_err = bus.out_err;
            h_ctl = bus.alu_control; h_s1 = bus.alu_src1; h_s2 = bus.alu_src2;
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk({tag, ".spurious"}, 32'(bus.out_valid), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk({tag, ".result"}, bus.out_result, e.res);
                    chk({tag, ".err"}, 32'(bus.out_err), 32'(e.err));
                    if (!e.err) chk({tag, ".rd"}, 32'(bus.out_rd), 32'(e.rd));
                end
            end
            if (bus.in_valid && bus.in_ready)
                q.push_back(ref_model(bus.in_instr, bus.in_rs_val, bus.in_rt_val));
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_rs_val = '0;
        bus.in_rt_val = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        chk("reset.ctl",       32'(bus.alu_control), 32'd0);
        chk("reset.src1",      bus.alu_src1, 32'd0);
        chk("reset.src2",      bus.alu_src2, 32'd0);
        chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset.out_bits",  {bus.out_result[25:0], bus.out_rd, bus.out_err}, 32'd0);
        rst = 1'b0;
        #1;
        chk("reset.in_ready",  32'(bus.in_ready), 32'd1);

        issue_one("add",     32'h0085_1020, 32'd5,  32'd7);
        issue_one("addi",    32'h2023_FFFF, 32'd10, 32'd0);
        issue_one("ori",     32'h3423_FFFF, 32'd0,  32'd0);
        issue_one("lui",     32'h3C03_1234, 32'h55, 32'h66);
        issue_one("sll",     32'h0005_1100, 32'd9,  32'd3);
        issue_one("srav",    32'h0085_1007, 32'd1,  32'h8000_0000);
        issue_one("slti",    32'h2823_8000, 32'hFFFF_0000, 32'd0);
        issue_one("badop",   32'h8C43_0000, 32'd1,  32'd2);
        issue_one("badfn",   32'h0085_1001, 32'd1,  32'd2);
        issue_one("sub",     32'h0085_1022, 32'd20, 32'd7);

        run_stream("bp",    12, 0);
        run_stream("bpdr",   6, 3);
        chk("bp.drained", 32'(q.size()), 32'd0);
        run_stream("tput",  10, 2);
        run_stream("tpdr",   6, 3);
        chk("tput.drained", 32'(q.size()), 32'd0);
        run_stream("rand", 300, 1);
        run_stream("rndr",   6, 3);
        chk("rand.drained", 32'(q.size()), 32'd0);

        // Fill both stages with output stalled, then reset with a pending accept.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h0085_1020;
        bus.in_rs_val = 32'd1;
        bus.in_rt_val = 32'd2;
        tick();
        tick();
        chk("rstmid.full_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rstmid.full_valid",    32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        tick();
        chk("rstmid.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rstmid.ctl",       32'(bus.alu_control), 32'd0);
        chk("rstmid.src",       bus.alu_src1 | bus.alu_src2, 32'd0);
        chk("rstmid.result",    bus.out_result, 32'd0);
        rst = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rstmid.no_stale", 32'(bus.out_valid), 32'd0);
        end
        issue_one("post_rst", 32'h0085_1024, 32'hF0F0_1234, 32'h0FF0_FFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Issue/writeback front end for the one-hot-controlled combinational `alu`. It accepts MIPS-style ALU instructions plus register operand values on a valid/ready stream and decodes each into the 12-bit one-hot `alu_control` word and operands. It drives those, registered, into `alu`, then captures `alu_result` into a result register that feeds a valid/ready output stream toward register writeback. It is the initiator side of the ALU interface.

## Interface
- `DATA_WIDTH`, 32, operand/result width; must be ≥16.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: instruction request valid.
- `in_ready` out 1: request accepted when `in_valid & in_ready` at a rising edge.
- `in_instr` in 32: MIPS instruction word.
- `in_rs_val` in DATA_WIDTH: value of register rs.
- `in_rt_val` in DATA_WIDTH: value of register rt.
- `alu_control` out 12: one-hot op to `alu`, with bits [11:0] = add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
- `alu_src1` out DATA_WIDTH: ALU operand 1. For shifts this carries the shift amount.
- `alu_src2` out DATA_WIDTH: ALU operand 2. For shifts this carries the data; for lui it carries the immediate.
- `alu_result` in DATA_WIDTH: combinational result returned from `alu`.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts when `out_valid & out_ready`.
- `out_result` out DATA_WIDTH: captured result.
- `out_rd` out 5: destination register number.
- `out_err` out 1: instruction was unsupported; `out_result` is 0.

## Operation
- **Decode, opcode 0.** The funct field is `instr[5:0]`. Destination is `rd = instr[15:11]`.
  - 0x20 and 0x21 → add; 0x22 and 0x23 → sub.
  - 0x2A → slt; 0x2B → sltu.
  - 0x24 → and; 0x25 → or; 0x26 → xor; 0x27 → nor. Operands are src1 = rs, src2 = rt.
  - 0x00, 0x02, 0x03 → sll, srl, sra. Operands are src1 = zero-extended `instr[10:6]`, src2 = rt.
  - 0x04, 0x06, 0x07 → sllv, srlv, srav. Operands are src1 = rs, src2 = rt.
- **Decode, I-type.** Destination is `rd = instr[20:16]`. src1 = rs. imm = `instr[15:0]`.
  - 0x08 and 0x09 → add; 0x0A → slt; 0x0B → sltu. src2 = sign-extended imm.
  - 0x0C → and; 0x0D → or; 0x0E → xor. src2 = zero-extended imm.
  - 0x0F → lui. src1 = 0, src2 = zero-extended imm.
- **Unsupported instructions.** Any other opcode/funct is still accepted and flows down the pipe. `alu_control` = 0 (src1/src2 = 0) and `err` = 1. Stage 2 forces `out_result` to 0 instead of capturing `alu_result`.
- **Stage 1 (issue register).** Holds `alu_control`, `alu_src1`, `alu_src2`, rd, err and `s1_valid`. While `s1_valid` = 0, `alu_control` = 0 and both operands = 0.
- **Stage 2 (result register).** Holds `out_result`, `out_rd`, `out_err` and `out_valid`. On each advance it captures `alu_result` from stage 1.
- **Flow control.** Standard two-stage elastic pipe, full throughput.
  - `s2_free = !out_valid | out_ready`
  - `s1_adv = s1_valid & s2_free`
  - `in_ready = !s1_valid | s2_free` (combinational; no combinational path from `in_valid`)
- **Output stability.** While `out_valid & !out_ready`, all `out_*` hold stable. Stage 1 also holds its contents, so `alu_control`, `alu_src1` and `alu_src2` are stable too.

## Timing
- **Reset.** All registered outputs are 0 one cycle after `rst` is sampled high: `alu_control`, `alu_src1`, `alu_src2`, `out_valid`, `out_result`, `out_rd`, `out_err`. `in_ready` = 1 while `rst` is low and the pipe is empty.
- **Reset mid-operation.** Both stages are discarded and nothing is emitted afterwards. `rst` overrides a simultaneous accept.
- **Latency.** An instruction accepted at edge N drives the ALU in cycle N..N+1. `out_valid` rises after edge N+1, giving 2 cycles to result.
- **Throughput.** One instruction per cycle with `out_ready` held high.
- **Backpressure.**
  - Stage 1 full and stage 2 stalled: `in_ready` = 0.
  - Stage 2 draining while stage 1 refills in the same edge is legal.
  - Stage 1 advancing while the input is accepted in the same edge is legal.
- **Arithmetic.** addu/addiu map to add; overflow is not trapped. Sign extension replicates `instr[15]` to DATA_WIDTH.

## Structure
- **Shared package `alu_pkg`:**
  - opcode and funct constants;
  - localparams for the one-hot `alu_control` bit positions (ADD = 11 … LUI = 0);
  - the 12-bit "no-op" constant.
- **Sub-module `alu_issue_decode`:** purely combinational. It maps instr, rs and rt to control, src1, src2, rd and err. The top level holds the two pipeline stages and the handshake.

## Test plan
- **Basic add.** Reset, then `in_instr` = 0x00851020 (add $2,$4,$5) with rs = 5, rt = 7 → `alu_control` = 0x800, src1 = 5, src2 = 7. After 2 edges: `out_valid` = 1, `out_result` = 12, `out_rd` = 2, `out_err` = 0.
- **Immediate extension.**
  - addi $3,$1,-1 (0x2023FFFF) with rs = 10 → src2 = 0xFFFFFFFF, result 9, rd = 3.
  - ori $3,$1,0xFFFF with rs = 0 → src2 = 0x0000FFFF.
  - lui (0x3C031234) → `alu_control` = 0x001, src2 = 0x00001234.
- **Shift operand swap.** sll $2,$5,4 (0x00051100) with rt = 3 → `alu_control` = 0x008, src1 = 4, src2 = 3, result 48. srav with rs = 1, rt = 0x80000000 → `alu_control` = 0x002, src1 = 1, src2 = 0x80000000.
- **Unsupported instruction.** Opcode 0x23 → `alu_control` = 0, `out_err` = 1, `out_result` = 0. The next valid instruction still completes normally.
- **Backpressure stream.** 6 back-to-back instructions with `out_ready` toggling 1,0,0,1,… → every result is emitted exactly once in order. Outputs are stable while stalled. `in_ready` = 0 only when both stages are full and stalled. Full-throughput segments show one result per cycle.
- **Reset mid-stream.** Assert `rst` with both stages full → next cycle `out_valid` = 0 and `alu_control` = 0. No stale result appears after release.
